// File: rtl/synth_pkg.sv
// Shared types and helpers for the voice scheduler and its sine table.
package synth_pkg;

  localparam int unsigned VoicesDef     = 4;
  localparam int unsigned PhaseWidthDef = 16;

  typedef logic [PhaseWidthDef-1:0]        phase_t;
  typedef logic [$clog2(VoicesDef)-1:0]    voice_idx_t;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

  // Peak amplitude of a signed sample of the given width.
  function automatic int sine_amp_f(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/sine_lut.sv
// One full sine period, synchronous single-cycle read.
module sine_lut
  import synth_pkg::*;
#(
  parameter int unsigned width_p          = 12,
  parameter int unsigned lut_depth_log2_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [lut_depth_log2_p-1:0]    addr_i,
  output logic signed [width_p-1:0]      data_o
);

  localparam int Depth = 1 << lut_depth_log2_p;

  logic signed [width_p-1:0] w_rom [Depth];
  logic signed [width_p-1:0] r_data;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_rom
    assign w_rom[gi] = width_p'($rtoi(real'(sine_amp_f(width_p)) *
                                      $sin(2.0 * $acos(-1.0) * real'(gi) / real'(Depth))));
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_data <= '0;
    end else begin
      r_data <= w_rom[addr_i];
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexed sine voices summed into one sample per tick.
// Define VOICE_SATURATE_EN to clamp the sum instead of averaging it.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned width_p          = 12,
  parameter int unsigned voices_p         = VoicesDef,
  parameter int unsigned phase_width_p    = PhaseWidthDef,
  parameter int unsigned lut_depth_log2_p = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          tick_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(voices_p)-1:0]   cfg_voice_i,
  input  logic [phase_width_p-1:0]      cfg_inc_i,
  input  logic                          cfg_en_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic signed [width_p-1:0]     data_o,
  output logic                          busy_o,
  output logic                          overrun_o
);

  localparam int unsigned IdxW = $clog2(voices_p);
  localparam int unsigned AccW = width_p + IdxW;

  state_e                         r_state;
  logic [IdxW-1:0]                r_idx;
  logic signed [AccW-1:0]         r_acc;
  logic [phase_width_p-1:0]       r_phase [voices_p];
  logic [phase_width_p-1:0]       r_inc   [voices_p];
  logic [voices_p-1:0]            r_en;
  logic                           r_rd_en;
  logic                           r_valid;
  logic signed [width_p-1:0]      r_data;
  logic                           r_overrun;

  logic [lut_depth_log2_p-1:0]    w_addr;
  logic signed [width_p-1:0]      w_lut;
  logic signed [AccW-1:0]         w_lut_ext;
  logic signed [AccW-1:0]         w_acc_sum;
  logic signed [width_p-1:0]      w_sample;

  assign w_addr = r_phase[r_idx][phase_width_p-1 -: lut_depth_log2_p];

  sine_lut #(
    .width_p          (width_p),
    .lut_depth_log2_p (lut_depth_log2_p)
  ) u_lut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .addr_i  (w_addr),
    .data_o  (w_lut)
  );

  // r_rd_en tracks whether the voice whose data is now arriving was enabled.
  assign w_lut_ext = r_rd_en ? AccW'(w_lut) : '0;
  assign w_acc_sum = r_acc + w_lut_ext;

`ifdef VOICE_SATURATE_EN
  localparam logic signed [AccW-1:0] SatMax = AccW'(sine_amp_f(width_p));
  localparam logic signed [AccW-1:0] SatMin = AccW'(-sine_amp_f(width_p) - 1);

  always_comb begin
    w_sample = width_p'(w_acc_sum);
    if (w_acc_sum > SatMax) begin
      w_sample = width_p'(SatMax);
    end else if (w_acc_sum < SatMin) begin
      w_sample = width_p'(SatMin);
    end
  end
`else
  always_comb begin
    w_sample = width_p'(w_acc_sum >>> IdxW);
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_acc     <= '0;
      r_en      <= '0;
      r_rd_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
      for (int v = 0; v < int'(voices_p); v++) begin
        r_phase[v] <= '0;
        r_inc[v]   <= '0;
      end
    end else begin
      r_overrun <= tick_i && (r_state != StIdle);
      unique case (r_state)
        StIdle: begin
          if (tick_i) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= StIssue;
          end
        end
        StIssue: begin
          r_rd_en <= r_en[r_idx];
          if (r_en[r_idx]) begin
            r_phase[r_idx] <= r_phase[r_idx] + r_inc[r_idx];
          end
          if (r_idx != '0) begin
            r_acc <= w_acc_sum;
          end
          if (r_idx == IdxW'(voices_p - 1)) begin
            r_state <= StDrain;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDrain: begin
          r_data  <= w_sample;
          r_valid <= 1'b1;
          r_state <= StHold;
        end
        StHold: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      // Written after the issue update so a same-cycle write lands but the
      // issue used the old increment; disabling also resets the phase.
      if (cfg_we_i) begin
        r_inc[cfg_voice_i] <= cfg_inc_i;
        r_en[cfg_voice_i]  <= cfg_en_i;
        if (!cfg_en_i) begin
          r_phase[cfg_voice_i] <= '0;
        end
      end
    end
  end

  assign valid_o   = r_valid;
  assign data_o    = r_data;
  assign busy_o    = (r_state != StIdle);
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a frame-level reference model.
module tb_voice_scheduler;

  localparam int V = 4;

`ifdef VOICE_SATURATE_EN
  localparam int P1 = 2047;
  localparam int N1 = -2047;
  localparam int P2 = 2047;
  localparam int N2 = -2048;
`else
  localparam int P1 = 511;
  localparam int N1 = -512;
  localparam int P2 = 1023;
  localparam int N2 = -1024;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick_i = 1'b0;
  logic               cfg_we_i = 1'b0;
  logic [1:0]         cfg_voice_i = '0;
  logic [15:0]        cfg_inc_i = '0;
  logic               cfg_en_i = 1'b0;
  logic               ready_i = 1'b1;
  logic               valid_o;
  logic signed [11:0] data_o;
  logic               busy_o;
  logic               overrun_o;

  int total = 0;
  int bad   = 0;

  voice_scheduler u_dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .tick_i      (tick_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_voice_i (cfg_voice_i),
    .cfg_inc_i   (cfg_inc_i),
    .cfg_en_i    (cfg_en_i),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level behaviour from the sine/mixing rules.
  int m_phase [V];
  int m_inc   [V];
  bit m_en    [V];
  bit m_active;
  int m_cnt;
  bit m_ovr;
  int m_data;

  function automatic int lut_f(input int i);
    return $rtoi(2047.0 * $sin(2.0 * $acos(-1.0) * real'(i) / 256.0));
  endfunction

  function automatic int mix_f(input int acc);
`ifdef VOICE_SATURATE_EN
    if (acc > 2047) return 2047;
    if (acc < -2048) return -2048;
    return acc;
`else
    return acc >>> 2;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit was_active;
    int sum;
    if (!rst_n) begin
      m_active = 0;
      m_cnt    = 0;
      m_ovr    = 0;
      m_data   = 0;
      for (int v = 0; v < V; v++) begin
        m_phase[v] = 0;
        m_inc[v]   = 0;
        m_en[v]    = 0;
      end
    end else begin
      was_active = m_active;
      m_ovr = tick_i && was_active;
      if (m_active) begin
        if (m_cnt >= V + 2 && ready_i) m_active = 0;
        else m_cnt++;
      end
      if (!was_active && tick_i) begin
        sum = 0;
        for (int v = 0; v < V; v++) begin
          if (m_en[v]) begin
            sum += lut_f(m_phase[v] >> 8);
            m_phase[v] = (m_phase[v] + m_inc[v]) & 16'hFFFF;
          end
        end
        m_data   = mix_f(sum);
        m_active = 1;
        m_cnt    = 1;
      end
      if (cfg_we_i) begin
        m_inc[cfg_voice_i] = int'(cfg_inc_i);
        m_en[cfg_voice_i]  = cfg_en_i;
        if (!cfg_en_i) m_phase[cfg_voice_i] = 0;
      end
    end
  end

  int last_sample;
  bit got;
  int ovr_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy_o), int'(m_active));
      chk("valid", int'(valid_o), int'(m_active && m_cnt >= V + 2));
      chk("overrun", int'(overrun_o), int'(m_ovr));
      if (valid_o) begin
        chk("data", int'(data_o), m_data);
        last_sample = int'(data_o);
        got = 1;
      end
      if (overrun_o) ovr_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int v, input int inc, input bit en);
    cfg_we_i    = 1'b1;
    cfg_voice_i = 2'(v);
    cfg_inc_i   = 16'(inc);
    cfg_en_i    = en;
    step();
    cfg_we_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic frame(output int s);
    got    = 0;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    repeat (6) step();
    chk("frame_valid_seen", int'(got), 1);
    s = last_sample;
  endtask

  initial begin
    int s;
    int ovr0;
    #12;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single voice, quarter-period steps.
    cfg(0, 16'h4000, 1'b1);
    frame(s); chk("single_0", s, 0);
    frame(s); chk("single_1", s, P1);
    frame(s); chk("single_2", s, 0);
    frame(s); chk("single_3", s, N1);

    // Two voices in phase.
    do_reset();
    cfg(0, 16'h4000, 1'b1);
    cfg(1, 16'h4000, 1'b1);
    frame(s); chk("dual_0", s, 0);
    frame(s); chk("dual_1", s, P2);

    // Back-pressure with a dropped tick.
    ready_i = 1'b0;
    got     = 0;
    tick_i  = 1'b1;
    step();
    tick_i = 1'b0;
    repeat (5) step();
    ovr0 = ovr_seen;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) tick_i = 1'b1;
      step();
      tick_i = 1'b0;
    end
    chk("hold_valid_seen", int'(got), 1);
    chk("hold_data", last_sample, 0);
    chk("overrun_pulses", ovr_seen - ovr0, 1);
    ready_i = 1'b1;
    step();
    repeat (4) step();
    chk("no_restart", int'(busy_o), 0);
    frame(s); chk("dual_after_hold", s, N2);

    // Reset in the middle of ISSUE.
    do_reset();
    cfg(0, 16'h4000, 1'b1);
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    step();
    rst_n = 1'b1;
    cfg(0, 16'h4000, 1'b1);
    frame(s); chk("midrst_first", s, 0);
    frame(s); chk("midrst_second", s, P1);

    // Increment rewritten while voice 2 is being issued.
    do_reset();
    cfg(2, 16'h4000, 1'b1);
    got    = 0;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    step();
    step();
    cfg(2, 16'h8000, 1'b1);
    repeat (3) step();
    chk("coll_valid_seen", int'(got), 1);
    chk("coll_0", last_sample, 0);
    frame(s); chk("coll_1", s, P1);
    frame(s); chk("coll_2", s, N1);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
